// File: rtl/video_timing_gen_pkg.sv
// rtl/video_timing_gen_pkg.sv - shared FSM state, timing record and validity helper for video_timing_gen
package video_timing_gen_pkg;

    // Raster sequencer: LOAD latches the timing, RUN scans pixels
    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Threshold storage width; counters of width W (W <= TW_MAX) are zero-extended into it
    localparam int TW_MAX = 16;

    typedef struct packed {
        logic [TW_MAX-1:0] total;
        logic [TW_MAX-1:0] blank;
        logic [TW_MAX-1:0] sync_s;
        logic [TW_MAX-1:0] sync_e;
    } axis_cfg_t;

    typedef struct packed {
        axis_cfg_t h;
        axis_cfg_t v;
    } timing_t;

    // A line needs at least two pixels and a frame at least one line
    function automatic logic cfg_valid(input logic [TW_MAX-1:0] h_total,
                                       input logic [TW_MAX-1:0] v_total);
        return (h_total >= TW_MAX'(2)) && (v_total >= TW_MAX'(1));
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - timing inputs and raster outputs of video_timing_gen (VIDEO_TIMING_SYNC_POL_EN adds sync polarity inputs)
interface video_timing_gen_if #(
    parameter int W = 11
);
    logic         en;
    logic [W-1:0] h_total;
    logic [W-1:0] h_blank;
    logic [W-1:0] h_sync_s;
    logic [W-1:0] h_sync_e;
    logic [W-1:0] v_total;
    logic [W-1:0] v_blank;
    logic [W-1:0] v_sync_s;
    logic [W-1:0] v_sync_e;
`ifdef VIDEO_TIMING_SYNC_POL_EN
    logic         hsync_pol;
    logic         vsync_pol;
`endif
    logic [W-1:0] h_count;
    logic [W-1:0] v_count;
    logic         blank;
    logic         hsync;
    logic         vsync;
    logic         line_end;
    logic         frame_end;
    logic         cfg_err;

`ifdef VIDEO_TIMING_SYNC_POL_EN
    modport master (
        output en, h_total, h_blank, h_sync_s, h_sync_e,
        output v_total, v_blank, v_sync_s, v_sync_e, hsync_pol, vsync_pol,
        input  h_count, v_count, blank, hsync, vsync, line_end, frame_end, cfg_err
    );
    modport slave (
        input  en, h_total, h_blank, h_sync_s, h_sync_e,
        input  v_total, v_blank, v_sync_s, v_sync_e, hsync_pol, vsync_pol,
        output h_count, v_count, blank, hsync, vsync, line_end, frame_end, cfg_err
    );
`else
    modport master (
        output en, h_total, h_blank, h_sync_s, h_sync_e,
        output v_total, v_blank, v_sync_s, v_sync_e,
        input  h_count, v_count, blank, hsync, vsync, line_end, frame_end, cfg_err
    );
    modport slave (
        input  en, h_total, h_blank, h_sync_s, h_sync_e,
        input  v_total, v_blank, v_sync_s, v_sync_e,
        output h_count, v_count, blank, hsync, vsync, line_end, frame_end, cfg_err
    );
`endif
endinterface

// File: rtl/video_timing_gen_timing_axis.sv
// rtl/video_timing_gen_timing_axis.sv - one raster axis: position counter, wrap, blank and sync decode
module timing_axis
    import video_timing_gen_pkg::*;
#(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         idle,
    input  logic         start,
    input  logic         step,
    input  axis_cfg_t    cfg,
    output logic [W-1:0] cnt,
    output logic         blank,
    output logic         sync,
    output logic         last
);
    logic [W-1:0]      cnt_nxt;
    logic [TW_MAX-1:0] cnt_ext;

    // Next position: restart at 0 on start, otherwise advance and wrap after the last position
    always_comb begin
        cnt_nxt = cnt;
        if (start) begin
            cnt_nxt = '0;
        end else if (step) begin
            cnt_nxt = last ? '0 : cnt + W'(1);
        end
    end

    assign cnt_ext = TW_MAX'(cnt_nxt);

    // Count and its decode are registered together so the flags describe the visible count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            blank <= 1'b1;
            sync  <= 1'b0;
            last  <= 1'b0;
        end else if (idle) begin
            cnt   <= '0;
            blank <= 1'b1;
            sync  <= 1'b0;
            last  <= 1'b0;
        end else if (start || step) begin
            cnt   <= cnt_nxt;
            blank <= (cnt_ext >= cfg.blank);
            sync  <= (cnt_ext >= cfg.sync_s) && (cnt_ext < cfg.sync_e);
            last  <= (cnt_ext == cfg.total - TW_MAX'(1));
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator with frame-boundary shadow reload (optional VIDEO_TIMING_SYNC_POL_EN)
module video_timing_gen
    import video_timing_gen_pkg::*;
#(
    parameter int W = 11
) (
    input logic               clk,
    input logic               rst,
    video_timing_gen_if.slave bus
);
    state_t  state;
    state_t  state_nxt;
    timing_t shadow;
    timing_t cfg_in;
    timing_t cfg_use;
    logic    cfg_err_q;
    logic    in_ok;
    logic    sh_ok;
    logic    reload;
    logic    idle;
    logic    start;
    logic    h_step;
    logic    v_step;
    logic    h_blank, h_sync, h_last;
    logic    v_blank, v_sync, v_last;

    // Timing inputs widened into the shared record
    always_comb begin
        cfg_in.h.total  = TW_MAX'(bus.h_total);
        cfg_in.h.blank  = TW_MAX'(bus.h_blank);
        cfg_in.h.sync_s = TW_MAX'(bus.h_sync_s);
        cfg_in.h.sync_e = TW_MAX'(bus.h_sync_e);
        cfg_in.v.total  = TW_MAX'(bus.v_total);
        cfg_in.v.blank  = TW_MAX'(bus.v_blank);
        cfg_in.v.sync_s = TW_MAX'(bus.v_sync_s);
        cfg_in.v.sync_e = TW_MAX'(bus.v_sync_e);
    end

    // Shadows load in LOAD or on the last pixel of a frame; the pixel after a load
    // is decoded with the incoming timing so the new frame starts clean
    assign in_ok   = cfg_valid(cfg_in.h.total, cfg_in.v.total);
    assign sh_ok   = cfg_valid(shadow.h.total, shadow.v.total);
    assign reload  = bus.en && ((state == LOAD) || (h_last && v_last));
    assign idle    = reload && !in_ok;
    assign start   = bus.en && (state == LOAD) && in_ok;
    assign h_step  = bus.en && (state == RUN) && sh_ok && !idle;
    assign v_step  = h_step && h_last;
    assign cfg_use = reload ? cfg_in : shadow;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // LOAD lasts one enabled clock; an invalid shadow sends RUN back to LOAD
    always_comb begin
        state_nxt = state;
        if (bus.en) begin
            if (state == LOAD) begin
                state_nxt = RUN;
            end else if (!sh_ok) begin
                state_nxt = LOAD;
            end
        end
    end

    // Shadow timing and configuration error flag, updated only on a load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow    <= '0;
            cfg_err_q <= 1'b0;
        end else if (reload) begin
            shadow    <= cfg_in;
            cfg_err_q <= !in_ok;
        end
    end

    timing_axis #(.W(W)) u_h_axis (
        .clk   (clk),
        .rst   (rst),
        .idle  (idle),
        .start (start),
        .step  (h_step),
        .cfg   (cfg_use.h),
        .cnt   (bus.h_count),
        .blank (h_blank),
        .sync  (h_sync),
        .last  (h_last)
    );

    timing_axis #(.W(W)) u_v_axis (
        .clk   (clk),
        .rst   (rst),
        .idle  (idle),
        .start (start),
        .step  (v_step),
        .cfg   (cfg_use.v),
        .cnt   (bus.v_count),
        .blank (v_blank),
        .sync  (v_sync),
        .last  (v_last)
    );

    assign bus.blank     = h_blank || v_blank;
    assign bus.line_end  = h_last && bus.en;
    assign bus.frame_end = h_last && v_last && bus.en;
    assign bus.cfg_err   = cfg_err_q;

`ifdef VIDEO_TIMING_SYNC_POL_EN
    logic hs_idle;
    logic vs_idle;

    // Idle sync levels (inverse of polarity) latch with the shadows; they reset low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_idle <= 1'b0;
            vs_idle <= 1'b0;
        end else if (reload) begin
            hs_idle <= ~bus.hsync_pol;
            vs_idle <= ~bus.vsync_pol;
        end
    end

    assign bus.hsync = h_sync ^ hs_idle;
    assign bus.vsync = v_sync ^ vs_idle;
`else
    assign bus.hsync = h_sync;
    assign bus.vsync = v_sync;
`endif

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter W, default 11: width of every counter and threshold.
REQ-002 SHALL have the following ports, one clock, reset asynchronous active-low:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- en  in  1  count enable; low holds all state.
- h_total, h_blank, h_sync_s, h_sync_e  in  W each  horizontal period, blank start, sync start, sync end.
- v_total, v_blank, v_sync_s, v_sync_e  in  W each  vertical equivalents, in lines.
- h_count, v_count  out  W each  current pixel and line.
- blank  out  1  high outside the active area.
- hsync, vsync  out  1 each  sync pulses.
- line_end  out  1  one-cycle pulse on the last pixel of a line.
- frame_end  out  1  one-cycle pulse on the last pixel of a frame.
- cfg_err  out  1  loaded timing is invalid.

Function
REQ-003 SHALL run a state machine with states LOAD and RUN; after reset it enters LOAD, spends exactly one clk there, then moves to RUN.
REQ-004 In LOAD, it SHALL copy all eight timing inputs into shadow registers; outputs SHALL hold their reset values.
REQ-005 The shadow registers SHALL reload only when frame_end is high and en is high, so timing changes take effect at frame boundaries only.
REQ-006 In RUN with en=1, h_count SHALL increment by one per clk and wrap to 0 after reaching shadow h_total-1.
REQ-007 v_count SHALL increment when h_count wraps, and SHALL wrap to 0 after reaching v_total-1.
REQ-008 With en=0, counters, outputs and the FSM state SHALL hold; line_end and frame_end SHALL be 0.
REQ-009 blank SHALL equal (h_count >= h_blank) OR (v_count >= v_blank), evaluated on the shadow values.
REQ-010 hsync SHALL be active while h_sync_s <= h_count < h_sync_e.
REQ-011 vsync SHALL be active while v_sync_s <= v_count < v_sync_e.
REQ-012 blank, hsync, vsync, line_end and frame_end SHALL be registered and cycle-aligned with the h_count/v_count they describe, with zero added latency.
REQ-013 line_end SHALL be 1 when h_count == h_total-1 and en=1; frame_end SHALL additionally require v_count == v_total-1.
REQ-014 If a sync window has start >= end, that sync output SHALL never be active.
REQ-015 If shadow h_total < 2 or v_total < 1, cfg_err SHALL be 1 and counters SHALL hold at 0.
- In this case, the FSM SHALL return to LOAD each clk until the configuration is valid.
REQ-016 All counter arithmetic SHALL be W-bit unsigned; h_total = 2^W-1 SHALL be legal.

Reset
REQ-017 On rst=0, asynchronously:
- h_count=0, v_count=0.
- blank=1.
- hsync and vsync inactive.
- line_end=0, frame_end=0, cfg_err=0.
- shadows=0, FSM=LOAD.
REQ-018 Reset asserted mid-frame SHALL abort the frame immediately; the sequence SHALL restart at LOAD after rst rises.

Configuration
REQ-019 With VIDEO_TIMING_SYNC_POL_EN defined:
- inputs hsync_pol and vsync_pol (1 bit each) SHALL be added and latched with the shadows.
- Active sync level SHALL equal the pol bit.
- The reset level of each sync output SHALL be its inactive level, which is ~pol and therefore 0 at reset.
REQ-020 Without VIDEO_TIMING_SYNC_POL_EN, sync outputs SHALL be active-high and the pol ports SHALL be absent.

Structure
REQ-021 A shared package SHALL hold the FSM state typedef (LOAD, RUN) and a timing-record typedef grouping the eight thresholds.
REQ-022 The block SHALL instantiate one sub-module, timing_axis, twice: one instance horizontal, one vertical.
- timing_axis provides counter, wrap, blank and sync decode.

Verification
REQ-023 The bench (W=10) SHALL cover:
- Reset, then h_total=8, h_blank=5, h_sync 6..7, v_total=4, v_blank=3, v_sync 3..4 -> after one LOAD clk:
  - h_count steps 0..7.
  - blank high at h_count=5..7.
  - hsync high only at h_count=6.
  - line_end pulses at h_count=7.
- Same setup, run 32 clks -> v_count steps 0..3; vsync high only on line 3; frame_end pulses once at (7,3).
- Change h_total to 10 mid-frame -> no change until after frame_end; the next frame has a 10-pixel line.
- Hold en=0 for 5 clks at h_count=4 -> all outputs frozen; resumes at 5.
- Set h_total=1 -> cfg_err=1 and counters stay 0.
  - Then set h_total=8 -> cfg_err=0 after LOAD.
- Assert rst at (3,2) -> all outputs take reset values immediately; the count restarts at (0,0) after LOAD.
